// File: rtl/vector_fetch_if.sv
// Signal bundle between vector_fetch and its environment:
// interrupt sources, page-select register bus, and the vector consumer.
interface vector_fetch_if;
  logic        nmi_req;
  logic        swi_req;
  logic        irq_req;
  logic        irq_mask;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_cs;
  logic        bus_rw;
  logic [4:0]  bus_ad;
  logic [7:0]  bus_di;
  logic        vec_valid;
  logic [23:0] vec_addr;
  logic [1:0]  vec_src;
  logic        vec_ack;
  logic        busy;

  modport master (
    input  nmi_req, swi_req, irq_req, irq_mask, bus_gnt, bus_di, vec_ack,
    output bus_req, bus_cs, bus_rw, bus_ad, vec_valid, vec_addr, vec_src, busy
  );

  modport slave (
    output nmi_req, swi_req, irq_req, irq_mask, bus_gnt, bus_di, vec_ack,
    input  bus_req, bus_cs, bus_rw, bus_ad, vec_valid, vec_addr, vec_src, busy
  );
endinterface

// File: rtl/vector_fetch.sv
// Interrupt/reset vector fetcher: arbitrates pending sources, reads a 3-byte
// big-endian vector over the page-select register bus, presents it until acked.
module vector_fetch (
  input logic            clk,
  input logic            rst,
  vector_fetch_if.master vif
);

  typedef enum logic [2:0] {IDLE, ARB, F0, F1, F2, F3, VALID} state_t;

  state_t      state;
  logic        boot_pend;
  logic        nmi_pend;
  logic        swi_pend;
  logic        nmi_q;
  logic        nmi_edge;
  logic        nmi_act;
  logic        swi_act;
  logic        irq_live;
  logic [4:0]  base;

  logic        bus_req_q;
  logic        bus_cs_q;
  logic [4:0]  bus_ad_q;
  logic        vec_valid_q;
  logic [23:0] vec_addr_q;
  logic [1:0]  vec_src_q;
  logic        busy_q;

  // Same-cycle requests take part in arbitration, so simultaneous arrivals
  // are ordered by priority rather than by which one is already latched.
  always_comb begin
    nmi_edge = vif.nmi_req & ~nmi_q;
    nmi_act  = nmi_pend | nmi_edge;
    swi_act  = swi_pend | vif.swi_req;
    irq_live = vif.irq_req & ~vif.irq_mask;
  end

  always_comb begin
    case (vec_src_q)
      2'd0:    base = 5'h14;
      2'd1:    base = 5'h17;
      2'd2:    base = 5'h1A;
      default: base = 5'h1D;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      boot_pend   <= 1'b1;
      nmi_pend    <= 1'b0;
      swi_pend    <= 1'b0;
      nmi_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_cs_q    <= 1'b0;
      bus_ad_q    <= '0;
      vec_valid_q <= 1'b0;
      vec_addr_q  <= '0;
      vec_src_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      nmi_q <= vif.nmi_req;
      if (nmi_edge)    nmi_pend <= 1'b1;
      if (vif.swi_req) swi_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (boot_pend || nmi_act || swi_act || irq_live) begin
            state     <= ARB;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
          // A fresh request coincident with consuming an older one stays pending.
          if (boot_pend) begin
            boot_pend <= 1'b0;
            vec_src_q <= 2'd3;
          end else if (nmi_act) begin
            nmi_pend  <= nmi_pend & nmi_edge;
            vec_src_q <= 2'd2;
          end else if (swi_act) begin
            swi_pend  <= swi_pend & vif.swi_req;
            vec_src_q <= 2'd1;
          end else if (irq_live) begin
            vec_src_q <= 2'd0;
          end
        end
        ARB: begin
          if (vif.bus_gnt) begin
            state    <= F0;
            bus_cs_q <= 1'b1;
            bus_ad_q <= base;
          end
        end
        F0: begin
          state    <= F1;
          bus_ad_q <= base + 5'd1;
        end
        F1: begin
          state              <= F2;
          vec_addr_q[23:16]  <= vif.bus_di;
          bus_ad_q           <= base + 5'd2;
        end
        F2: begin
          state             <= F3;
          vec_addr_q[15:8]  <= vif.bus_di;
          bus_cs_q          <= 1'b0;
          bus_ad_q          <= '0;
        end
        F3: begin
          state           <= VALID;
          vec_addr_q[7:0] <= vif.bus_di;
          bus_req_q       <= 1'b0;
          vec_valid_q     <= 1'b1;
        end
        VALID: begin
          if (vif.vec_ack) begin
            state       <= IDLE;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus_req_q   <= 1'b0;
          bus_cs_q    <= 1'b0;
          bus_ad_q    <= '0;
          vec_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign vif.bus_req   = bus_req_q;
  assign vif.bus_cs    = bus_cs_q;
  assign vif.bus_rw    = 1'b1;
  assign vif.bus_ad    = bus_ad_q;
  assign vif.vec_valid = vec_valid_q;
  assign vif.vec_addr  = vec_addr_q;
  assign vif.vec_src   = vec_src_q;
  assign vif.busy      = busy_q;

endmodule
